// File: rtl/gpio_input_capture.sv
// GPIO input capture: synchronizes the pad inputs into the wb_clk_i domain,
// detects per-pin rising/falling edges, latches enabled edges into sticky
// write-1-to-clear status bits and exposes everything on a Wishbone slave.
module gpio_input_capture #(
    parameter int          NUM_PINS    = 38,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0200
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_sync_o,
    output logic                irq_o
);

    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
    logic [NUM_PINS-1:0] prev_q;
    logic [NUM_PINS-1:0] rise_en_q;
    logic [NUM_PINS-1:0] fall_en_q;
    logic [NUM_PINS-1:0] status_q;

    logic [NUM_PINS-1:0] rise;
    logic [NUM_PINS-1:0] fall;
    logic [NUM_PINS-1:0] set_bits;
    logic [NUM_PINS-1:0] clr_bits;
    logic [NUM_PINS-1:0] wr_mask;
    logic [NUM_PINS-1:0] wr_data;

    logic        req;
    logic        hit;
    logic        wr_en;
    logic [2:0]  idx;
    logic        rise_wr;
    logic        fall_wr;
    logic        status_wr;
    logic [31:0] rd_data;

    logic [63:0] in64;
    logic [63:0] rise64;
    logic [63:0] fall64;
    logic [63:0] status64;

    // The two byte-offset bits carry no information for word registers.
    logic unused_adr_bits;
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // Shift register synchronizer; the oldest stage drives the pin levels.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
        end
    end

    assign gpio_sync_o = sync_q[SYNC_STAGES-1];

    assign rise     = gpio_sync_o & ~prev_q;
    assign fall     = ~gpio_sync_o & prev_q;
    assign set_bits = (rise & rise_en_q) | (fall & fall_en_q);
    assign irq_o    = |status_q;

    // Bus request decode: a new request is only accepted while ack is low,
    // which makes a held strobe acknowledge every other cycle.
    assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign hit       = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign idx       = wbs_adr_i[4:2];
    assign wr_en     = req & wbs_we_i & hit;
    assign rise_wr   = wr_en & (idx[2:1] == 2'b01);
    assign fall_wr   = wr_en & (idx[2:1] == 2'b10);
    assign status_wr = wr_en & (idx[2:1] == 2'b11);

    // Per-pin write mask: the pin must live in the addressed half (LO/HI)
    // and its byte lane must be enabled.
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin_mask
        assign wr_mask[i] = wbs_sel_i[(i % 32) / 8] & (idx[0] == ((i >= 32) ? 1'b1 : 1'b0));
        assign wr_data[i] = wbs_dat_i[i % 32];
    end

    assign clr_bits = status_wr ? (wr_data & wr_mask) : '0;

    // Zero-extend pin-wide registers to 64 bits so unused pins read 0.
    always_comb begin
        in64                      = '0;
        rise64                    = '0;
        fall64                    = '0;
        status64                  = '0;
        in64[NUM_PINS-1:0]        = gpio_sync_o;
        rise64[NUM_PINS-1:0]      = rise_en_q;
        fall64[NUM_PINS-1:0]      = fall_en_q;
        status64[NUM_PINS-1:0]    = status_q;
    end

    // Read multiplexer; addresses outside the block return 0.
    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (idx)
                3'd0:    rd_data = in64[31:0];
                3'd1:    rd_data = in64[63:32];
                3'd2:    rd_data = rise64[31:0];
                3'd3:    rd_data = rise64[63:32];
                3'd4:    rd_data = fall64[31:0];
                3'd5:    rd_data = fall64[63:32];
                3'd6:    rd_data = status64[31:0];
                default: rd_data = status64[63:32];
            endcase
        end
    end

    // Edge enable registers with byte-lane write masking.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else begin
            if (rise_wr) begin
                rise_en_q <= (rise_en_q & ~wr_mask) | (wr_data & wr_mask);
            end
            if (fall_wr) begin
                fall_en_q <= (fall_en_q & ~wr_mask) | (wr_data & wr_mask);
            end
        end
    end

    // Edge history and sticky status; a new edge beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            prev_q   <= '0;
            status_q <= '0;
        end else begin
            prev_q   <= gpio_sync_o;
            status_q <= (status_q & ~clr_bits) | set_bits;
        end
    end

    // Single-cycle acknowledge; read data is held until the next read,
    // and a write leaves 0 on the data bus.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else if (req) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? 32'h0 : rd_data;
        end else begin
            wbs_ack_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed self-checking bench for gpio_input_capture.
module tb_gpio_input_capture;

    localparam logic [31:0] BASE = 32'h3000_0200;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] dat_r;
    logic [37:0] gpio_in;
    logic [37:0] gpio_sync;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    gpio_input_capture dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (dat_w),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_r),
        .gpio_in     (gpio_in),
        .gpio_sync_o (gpio_sync),
        .irq_o       (irq)
    );

    // 100 MHz bus clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, reports on miscompare
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One Wishbone transfer; checks that ack comes one clock after the request
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, output logic [31:0] rdata);
        int  waited;
        logic got;
        @(negedge clk);
        stb   = 1'b1;
        cyc   = 1'b1;
        we    = w;
        adr   = a;
        dat_w = d;
        sel   = s;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
            got = ack;
        end
        checkOutput($sformatf("ack_latency_%08h", a), 64'(waited), 64'd1);
        rdata = dat_r;
        stb   = 1'b0;
        cyc   = 1'b0;
        we    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wbWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused_rd;
        applyStimulus(1'b1, a, d, s, unused_rd);
    endtask

    task automatic wbRead(input string tag, input logic [31:0] a, input logic [31:0] expected);
        logic [31:0] rd;
        applyStimulus(1'b0, a, 32'h0, 4'hF, rd);
        checkOutput(tag, 64'(rd), 64'(expected));
    endtask

    initial begin
        stb     = 1'b0;
        cyc     = 1'b0;
        we      = 1'b0;
        sel     = 4'h0;
        dat_w   = 32'h0;
        adr     = 32'h0;
        gpio_in = 38'h3F_FFFF_FFFF;
        rst_n   = 1'b0;

        // Reset state with all pins high
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_gpio_sync", 64'(gpio_sync), 64'h0);
        checkOutput("rst_ack", 64'(ack), 64'h0);
        checkOutput("rst_irq", 64'(irq), 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wbRead("in_lo_all_high", BASE + 32'h00, 32'hFFFF_FFFF);
        wbRead("in_hi_all_high", BASE + 32'h04, 32'h0000_003F);
        wbRead("status_lo_no_enable", BASE + 32'h18, 32'h0);
        checkOutput("irq_no_enable", 64'(irq), 64'h0);

        // Settle all pins low, then rising-edge latency on pin 0
        gpio_in = '0;
        repeat (4) @(posedge clk);
        #1;
        wbWrite(BASE + 32'h08, 32'h1, 4'hF);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("irq_after_edge1", 64'(irq), 64'h0);
        @(posedge clk); #1;
        checkOutput("irq_after_edge2", 64'(irq), 64'h0);
        checkOutput("sync_pin0_after_edge2", 64'(gpio_sync), 64'h1);
        @(posedge clk); #1;
        checkOutput("irq_after_edge3", 64'(irq), 64'h1);
        wbRead("status_lo_pin0", BASE + 32'h18, 32'h1);
        wbWrite(BASE + 32'h18, 32'h1, 4'hF);
        checkOutput("irq_after_w1c", 64'(irq), 64'h0);

        // Falling-only enable on pin 37
        wbWrite(BASE + 32'h14, 32'h20, 4'hF);
        gpio_in[37] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("irq_pin37_rise_ignored", 64'(irq), 64'h0);
        gpio_in[37] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("irq_pin37_fall", 64'(irq), 64'h1);
        wbRead("status_hi_pin37", BASE + 32'h1C, 32'h20);
        wbWrite(BASE + 32'h1C, 32'h20, 4'hF);

        // Same pulse on disabled pin 36
        gpio_in[36] = 1'b1;
        repeat (5) @(posedge clk);
        gpio_in[36] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        wbRead("status_hi_pin36_disabled", BASE + 32'h1C, 32'h0);
        checkOutput("irq_pin36_disabled", 64'(irq), 64'h0);
        wbRead("fall_en_hi_readback", BASE + 32'h14, 32'h20);

        // Byte-lane write
        wbWrite(BASE + 32'h08, 32'h0, 4'hF);
        wbWrite(BASE + 32'h08, 32'hFFFF_FFFF, 4'b0010);
        wbRead("rise_en_lo_byte1", BASE + 32'h08, 32'h0000_FF00);

        // Set status bit 3, then drop pin 3 (fall disabled)
        wbWrite(BASE + 32'h08, 32'h8, 4'hF);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        wbRead("status_lo_pin3", BASE + 32'h18, 32'h8);
        gpio_in[3] = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // New rising edge lands on the same clock as the W1C write
        @(negedge clk);
        gpio_in[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        wbWrite(BASE + 32'h18, 32'h8, 4'hF);
        checkOutput("irq_edge_beats_clear", 64'(irq), 64'h1);
        wbRead("status_lo_edge_beats_clear", BASE + 32'h18, 32'h8);
        wbWrite(BASE + 32'h18, 32'h8, 4'hF);
        checkOutput("irq_after_clear_pin3", 64'(irq), 64'h0);

        // Decode: out-of-block accesses
        wbRead("in_lo_pins_0_3", BASE + 32'h03, 32'h9);
        wbRead("unmapped_read", BASE + 32'h40, 32'h0);
        wbWrite(BASE + 32'h48, 32'hFFFF_FFFF, 4'hF);
        wbRead("rise_en_lo_after_unmapped_write", BASE + 32'h08, 32'h8);

        // Held strobe: ack every other cycle
        @(negedge clk);
        stb = 1'b1;
        cyc = 1'b1;
        we  = 1'b0;
        adr = BASE + 32'h00;
        sel = 4'hF;
        checkOutput("held_ack_0", 64'(ack), 64'h0);
        @(negedge clk);
        checkOutput("held_ack_1", 64'(ack), 64'h1);
        @(negedge clk);
        checkOutput("held_ack_2", 64'(ack), 64'h0);
        @(negedge clk);
        checkOutput("held_ack_3", 64'(ack), 64'h1);
        checkOutput("held_read_data", 64'(dat_r), 64'h9);
        stb = 1'b0;
        cyc = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a transfer is being acknowledged
        @(negedge clk);
        stb = 1'b1;
        cyc = 1'b1;
        adr = BASE + 32'h00;
        @(posedge clk);
        #1;
        checkOutput("ack_before_reset", 64'(ack), 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("ack_dropped_by_reset", 64'(ack), 64'h0);
        checkOutput("dat_cleared_by_reset", 64'(dat_r), 64'h0);
        checkOutput("sync_cleared_by_reset", 64'(gpio_sync), 64'h0);
        stb = 1'b0;
        cyc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpio_input_capture.md
Name: gpio_input_capture

Overview:
- Input-direction counterpart of the GPIO output mux: samples the 38 caravel GPIO input pins into the wb_clk_i domain and detects per-pin rising and falling edges.
- Latches enabled edges into sticky status bits and raises an interrupt.
- Exposes pin levels, edge enables and status through a Wishbone slave on the management bus.
- Sits beside the output mux in the user project wrapper, between the io_in pads and the management SoC.

Parameters:
- NUM_PINS, 38, number of GPIO inputs handled (1..64).
- SYNC_STAGES, 2, synchronizer depth per pin (2..4).
- BASE_ADDR, 32'h3000_0200, register block base; 32-byte aligned.

Ports:
- wb_clk_i  input  1  system/Wishbone clock.
- wb_rst_ni  input  1  reset, asynchronous, active-low.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte lane enables.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  byte address.
- wbs_ack_o  output  1  transfer acknowledge.
- wbs_dat_o  output  32  read data.
- gpio_in  input  NUM_PINS  raw asynchronous pad inputs.
- gpio_sync_o  output  NUM_PINS  synchronized pin levels for user designs.
- irq_o  output  1  interrupt; high while any status bit is set.

Behaviour:
- Interface: one clock, wb_clk_i. Reset wb_rst_ni is asynchronous, active-low.
- Reset clears every flop to 0: all synchronizer stages, prev, RISE_EN, FALL_EN, STATUS, wbs_ack_o and wbs_dat_o. Hence gpio_sync_o=0 and irq_o=0 during reset. Reset asserted mid-transaction drops ack immediately; the transfer is lost.
- Synchronizer: gpio_sync_o = last of SYNC_STAGES flops. An input change is visible on gpio_sync_o SYNC_STAGES rising edges after it is first sampled.
- Edge detect: prev <= gpio_sync_o each cycle.
  - rise[i] = sync[i] & ~prev[i].
  - fall[i] = ~sync[i] & prev[i].
  - STATUS[i] sets on the cycle after the edge appears, when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - Input to STATUS latency: SYNC_STAGES+1 clocks.
- irq_o = |STATUS (combinational from registers). Edges on disabled pins are never recorded. Clearing an enable does not clear already-set STATUS bits.
- Register map (offset from BASE_ADDR, 32-bit word, bits at or above NUM_PINS read 0 and ignore writes):
  - 0x00 IN_LO: RO, pins 31:0.
  - 0x04 IN_HI: RO, pins 63:32.
  - 0x08 RISE_EN_LO, 0x0C RISE_EN_HI: RW.
  - 0x10 FALL_EN_LO, 0x14 FALL_EN_HI: RW.
  - 0x18 STATUS_LO, 0x1C STATUS_HI: read; write-1-to-clear.
- Byte lanes: writes honour wbs_sel_i per byte. Writes to IN regs are ignored.
- Simultaneous W1C clear and new qualifying edge on the same bit: the edge wins and the bit remains 1.
- Handshake:
  - A request is stb&cyc with ack low. wbs_ack_o goes high for exactly one cycle on the next clock.
  - Write takes effect and read data is registered on that same clock edge.
  - wbs_dat_o holds the last read value; it is 0 after writes.
  - Back-to-back requests are acked every other cycle.
- Decode: match on adr_i[31:5]==BASE_ADDR[31:5], index adr_i[4:2].
  - Non-matching addresses are still acked; reads return 0 and writes are ignored, so the bus never hangs.
  - wbs_adr_i[1:0] is ignored.
- Pin stable for less than 1 clock may be missed; the block has no debouncing.

Test Plan:
- Reset with gpio_in=38'h3F_FFFF_FFFF → gpio_sync_o, wbs_ack_o, irq_o all 0. Release reset; read IN_LO → 32'hFFFF_FFFF and IN_HI → 32'h0000_003F. STATUS stays 0 because enables are 0.
- Write RISE_EN_LO=32'h1; drive gpio_in[0] 0→1 → STATUS_LO=1 and irq_o=1 exactly 3 clocks after the first sampling edge. Write STATUS_LO=1 → irq_o=0 the next cycle.
- Write FALL_EN_HI=32'h20 (pin 37); pulse pin 37 high then low → only the falling edge sets STATUS_HI bit 5. Same pulse on pin 36 (disabled) → no status.
- Write RISE_EN_LO=32'hFFFF_FFFF with wbs_sel_i=4'b0010 → readback 32'h0000_FF00.
- Rising edge on pin 3 on the same clock as a W1C write of 32'h8 to STATUS_LO → bit 3 reads 1 and irq_o stays 1.
- Read at BASE_ADDR+0x40 → ack after 1 cycle, data 0. Hold stb/cyc high for 4 cycles → ack pattern 0,1,0,1. Assert reset during a pending request → ack low immediately.
